// File: rtl/serial_slice_adder.sv
// Multi-cycle adder/subtractor: ripples SLICE bits per clock through a registered
// carry, with valid/ready handshakes on the operand and result sides.
module serial_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             C_in,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             C_out,
  output logic             OVF
);

  if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("serial_slice_adder: SLICE must divide WIDTH and lie in 1..WIDTH");
  end

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  int                 idx;
  logic [SLICE-1:0]   x_sl, y_sl, s_sl;
  logic               c_sl;
  logic               last;

  // One SLICE-bit adder; y_q already holds ~Y for subtraction.
  always_comb begin
    idx  = int'(cnt_q) * SLICE;
    x_sl = x_q[idx +: SLICE];
    y_sl = y_q[idx +: SLICE];
    {c_sl, s_sl} = {1'b0, x_sl} + {1'b0, y_sl} + {{SLICE{1'b0}}, c_q};
    last = (cnt_q == CNT_W'(N - 1));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    c_d         = c_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          x_d        = X;
          y_d        = SUB ? ~Y : Y;
          c_d        = SUB ^ C_in;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        sum_d[idx +: SLICE] = s_sl;
        c_d   = c_sl;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          // Carry into the MSB is recovered from the MSB's own sum bit.
          cout_d      = c_sl;
          ovf_d       = x_sl[SLICE-1] ^ y_sl[SLICE-1] ^ s_sl[SLICE-1] ^ c_sl;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand and carry registers carry no reset; they are reloaded on every accept.
  always_ff @(posedge CLK) begin
    x_q <= x_d;
    y_q <= y_d;
    c_q <= c_d;
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign SUM       = sum_q;
  assign C_out     = cout_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_serial_slice_adder.sv
// Bench for serial_slice_adder: three instances (8/2, 16/16, 16/1) checked against
// directed vectors and a plain-arithmetic reference model.
module tb_serial_slice_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv   [3];
  logic        ordy [3];
  logic [15:0] xa   [3];
  logic [15:0] ya   [3];
  logic        ci   [3];
  logic        sb   [3];

  logic        irdy [3];
  logic        ovld [3];
  logic        co   [3];
  logic        ov   [3];
  logic [15:0] sm   [3];

  logic        irdy0, irdy1, irdy2, ovld0, ovld1, ovld2;
  logic        co0, co1, co2, ov0, ov1, ov2;
  logic [7:0]  sum0;
  logic [15:0] sum1, sum2;

  int errors = 0;
  int checks = 0;

  serial_slice_adder #(.WIDTH(8), .SLICE(2)) u_w8s2 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(iv[0]), .IN_READY(irdy0),
    .X(xa[0][7:0]), .Y(ya[0][7:0]), .C_in(ci[0]), .SUB(sb[0]),
    .OUT_VALID(ovld0), .OUT_READY(ordy[0]), .SUM(sum0), .C_out(co0), .OVF(ov0)
  );

  serial_slice_adder #(.WIDTH(16), .SLICE(16)) u_w16s16 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(iv[1]), .IN_READY(irdy1),
    .X(xa[1]), .Y(ya[1]), .C_in(ci[1]), .SUB(sb[1]),
    .OUT_VALID(ovld1), .OUT_READY(ordy[1]), .SUM(sum1), .C_out(co1), .OVF(ov1)
  );

  serial_slice_adder #(.WIDTH(16), .SLICE(1)) u_w16s1 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(iv[2]), .IN_READY(irdy2),
    .X(xa[2]), .Y(ya[2]), .C_in(ci[2]), .SUB(sb[2]),
    .OUT_VALID(ovld2), .OUT_READY(ordy[2]), .SUM(sum2), .C_out(co2), .OVF(ov2)
  );

  always_comb begin
    irdy[0] = irdy0; irdy[1] = irdy1; irdy[2] = irdy2;
    ovld[0] = ovld0; ovld[1] = ovld1; ovld[2] = ovld2;
    co[0]   = co0;   co[1]   = co1;   co[2]   = co2;
    ov[0]   = ov0;   ov[1]   = ov1;   ov[2]   = ov2;
    sm[0]   = {8'h00, sum0};
    sm[1]   = sum1;
    sm[2]   = sum2;
  end

  function automatic int width_of(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
  endfunction

  // Reference: integer arithmetic on the operand values, overflow from signed range.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic c, input logic s,
                                output logic [15:0] r, output logic cf, output logic vf);
    longint m, ua, ub, full, sa, sbv, sr;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    if (!s) begin
      full = ua + ub + longint'(c);
      cf   = (full >= m);
    end else begin
      full = ua - ub - longint'(c);
      cf   = (ua >= ub + longint'(c));
    end
    r   = 16'(full & (m - 1));
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    sr  = s ? (sa - sbv - longint'(c)) : (sa + sbv + longint'(c));
    vf  = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s);
    int n;
    n = 0;
    while (!irdy[d] && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!irdy[d]) begin
      errors++;
      $display("FAIL in_ready_timeout dut=%0d: in_ready=%0b required 1", d, irdy[d]);
    end
    xa[d] = a; ya[d] = b; ci[d] = c; sb[d] = s;
    iv[d] = 1'b1;
    tick();
    iv[d] = 1'b0;
  endtask

  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s,
                        output logic [15:0] r, output logic cf, output logic vf, output int lat);
    start_op(d, a, b, c, s);
    lat = 0;
    while (!ovld[d] && lat < 40) begin
      tick();
      lat++;
    end
    r  = sm[d];
    cf = co[d];
    vf = ov[d];
    ordy[d] = 1'b1;
    tick();
    ordy[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; xa[d] = '0; ya[d] = '0; ci[d] = 1'b0; sb[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (irdy[d] !== 1'b1 || ovld[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_handshake dut=%0d: in_ready=%0b out_valid=%0b required 1/0", d, irdy[d], ovld[d]);
      end
      checks++;
      if (sm[d] !== 16'h0 || co[d] !== 1'b0 || ov[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dut=%0d: sum=%h c_out=%0b ovf=%0b required 0/0/0", d, sm[d], co[d], ov[d]);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1/0", irdy[0], ovld[0]);
    end
  endtask

  task automatic test_directed();
    logic [15:0] vx [5] = '{16'hFF, 16'h7F, 16'h80, 16'h05, 16'h80};
    logic [15:0] vy [5] = '{16'h01, 16'h01, 16'hFF, 16'h07, 16'h01};
    logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [5] = '{16'h00, 16'h80, 16'h80, 16'hFE, 16'h7F};
    logic        ec [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        eo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] r;
    logic        cf, vf;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(0, vx[i], vy[i], vc[i], vs[i], r, cf, vf, lat);
      checks++;
      if (r !== es[i] || cf !== ec[i] || vf !== eo[i]) begin
        errors++;
        $display("FAIL directed_%0d: sum=%h c_out=%0b ovf=%0b required %h/%0b/%0b",
                 i, r, cf, vf, es[i], ec[i], eo[i]);
      end
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL directed_latency_%0d: latency=%0d required 4", i, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = -1; second = -1;
    xa[0] = 16'h12; ya[0] = 16'h34; ci[0] = 1'b0; sb[0] = 1'b0;
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (ovld[0]) begin
        checks++;
        if (sm[0] !== 16'h46) begin
          errors++;
          $display("FAIL back_to_back_sum: sum=%h required 46", sm[0]);
        end
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
    end
    iv[0] = 1'b0;
    repeat (10) tick();
    ordy[0] = 1'b0;
    checks++;
    if (first < 0 || second < 0 || (second - first) != 6) begin
      errors++;
      $display("FAIL back_to_back_period: period=%0d required 6", second - first);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(0, 16'h33, 16'h44, 1'b1, 1'b0);
    lat = 0;
    while (!ovld[0] && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL backpressure_latency: latency=%0d required 4", lat);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        xa[0] = 16'hAA; ya[0] = 16'h11; ci[0] = 1'b0; sb[0] = 1'b1; iv[0] = 1'b1;
      end
      if (i == 2) iv[0] = 1'b0;
      tick();
      checks++;
      if (sm[0] !== 16'h78 || co[0] !== 1'b0 || ov[0] !== 1'b0 || ovld[0] !== 1'b1 || irdy[0] !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: sum=%h c=%0b ovf=%0b ovld=%0b irdy=%0b required 78/0/0/1/0",
                 i, sm[0], co[0], ov[0], ovld[0], irdy[0]);
      end
    end
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    checks++;
    if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%0b in_ready=%0b required 0/1", ovld[0], irdy[0]);
    end
    repeat (6) tick();
    checks++;
    if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_ignored_pulse: out_valid=%0b in_ready=%0b required 0/1", ovld[0], irdy[0]);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] r;
    logic        cf, vf;
    int          lat;
    start_op(0, 16'h5A, 16'h21, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0 || sm[0] !== 16'h0 || co[0] !== 1'b0 || ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: irdy=%0b ovld=%0b sum=%h c=%0b ovf=%0b required 1/0/0000/0/0",
               irdy[0], ovld[0], sm[0], co[0], ov[0]);
    end
    tick();
    rst_n = 1'b1;
    run_op(0, 16'h10, 16'h20, 1'b0, 1'b0, r, cf, vf, lat);
    checks++;
    if (r !== 16'h30 || cf !== 1'b0 || vf !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL reset_recover: sum=%h c=%0b ovf=%0b latency=%0d required 30/0/0/4", r, cf, vf, lat);
    end
  endtask

  task automatic test_random(input int d, input int count);
    logic [15:0] a, b, r, er;
    logic        c, s, cf, vf, ec, eo;
    int          lat;
    for (int i = 0; i < count; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      s = 1'($urandom);
      if (i < 4) begin
        a = (i[0]) ? 16'hFFFF : 16'h8000;
        b = (i[1]) ? 16'h7FFF : 16'hFFFF;
      end
      run_op(d, a, b, c, s, r, cf, vf, lat);
      model(width_of(d), a, b, c, s, er, ec, eo);
      checks++;
      if (r !== er) begin
        errors++;
        $display("FAIL random_sum dut=%0d op=%0d: sum=%h required %h", d, i, r, er);
      end
      checks++;
      if (cf !== ec) begin
        errors++;
        $display("FAIL random_cout dut=%0d op=%0d: c_out=%0b required %0b", d, i, cf, ec);
      end
      checks++;
      if (vf !== eo) begin
        errors++;
        $display("FAIL random_ovf dut=%0d op=%0d: ovf=%0b required %0b", d, i, vf, eo);
      end
      checks++;
      if (lat !== lat_of(d)) begin
        errors++;
        $display("FAIL random_latency dut=%0d op=%0d: latency=%0d required %0d", d, i, lat, lat_of(d));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_random(0, 200);
    test_random(1, 1000);
    test_random(2, 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_slice_adder.md
# serial_slice_adder

Multi-cycle, parametrised successor to the single-bit full adder. Adds (or subtracts) two WIDTH-bit operands by rippling SLICE bits per clock through a registered carry, trading latency for a short carry chain. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It also reports unsigned carry/borrow and signed overflow.

## Interface
- WIDTH, default 16: operand and result width in bits; must be ≥ 1.
- SLICE, default 4: bits added per cycle; 1 ≤ SLICE ≤ WIDTH, WIDTH % SLICE == 0. Elaboration fails otherwise.
- CLK  input  1  single clock; all state changes on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  the producer has an operation on X, Y, C_in, SUB.
- IN_READY  output  1  the block can accept an operation.
- X  input  WIDTH  operand A.
- Y  input  WIDTH  operand B.
- C_in  input  1  carry-in (SUB=0) or borrow-in (SUB=1).
- SUB  input  1  0: X+Y+C_in; 1: X−Y−C_in.
- OUT_VALID  output  1  SUM, C_out and OVF hold a finished result.
- OUT_READY  input  1  the consumer takes the result.
- SUM  output  WIDTH  result, modulo 2^WIDTH.
- C_out  output  1  carry-out (SUB=0) or NOT borrow-out (SUB=1).
- OVF  output  1  two's-complement overflow.

## Operation
- N = WIDTH/SLICE slice steps per operation.
- States:
  - IDLE: IN_READY=1, OUT_VALID=0.
  - BUSY: IN_READY=0, OUT_VALID=0; step counter cnt runs 0..N−1.
  - DONE: IN_READY=0, OUT_VALID=1.
- Accept: IN_VALID & IN_READY at an edge.
  - Latch X and Y' = SUB ? ~Y : Y.
  - Carry register c = SUB ? ~C_in : C_in.
  - cnt=0, go to BUSY. SUB, C_in, X and Y are sampled only at this edge.
- BUSY step, each edge:
  - {c, SUM[cnt*SLICE +: SLICE]} = X[slice] + Y'[slice] + c.
  - cnt increments.
  - On the edge where cnt=N−1: go to DONE, C_out = final c, OVF = carry into bit WIDTH−1 XOR final c.
- DONE: when OUT_READY=1 at an edge, go to IDLE. Otherwise hold SUM, C_out and OVF stable for as long as needed (back-pressure).
- Result bits not yet computed are unspecified while OUT_VALID=0. Consumers look only at OUT_VALID.
- No pipelining: one operation in flight. IN_READY stays 0 from acceptance until the cycle after the result handshake.
- IN_VALID while IN_READY=0 is ignored; the producer must hold it.
- Reset (RST_N=0, any time, including mid-BUSY):
  - State goes to IDLE immediately and the operation is discarded.
  - cnt=0, SUM=0, C_out=0, OVF=0, OUT_VALID=0.
  - IN_READY=1 while RST_N=0 is low and after release.

## Timing
- Acceptance at edge t0: BUSY steps occur at edges t0+1..t0+N, and OUT_VALID=1 after edge t0+N. Latency is N cycles from acceptance to valid result.
- With OUT_READY held at 1: output handshake at edge t0+N+1, IN_READY=1 after it, next acceptance no earlier than t0+N+2. Peak throughput is one operation per N+2 cycles.
- SLICE=WIDTH: N=1, single-step operation, same handshake rules.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Critical path: one SLICE-bit adder plus carry register.

## Test plan
- WIDTH=8, SLICE=2, X=0xFF, Y=0x01, C_in=0, SUB=0 → SUM=0x00, C_out=1, OVF=0. OUT_VALID rises exactly 4 cycles after acceptance.
- WIDTH=8, SLICE=2, X=0x7F, Y=0x01, C_in=0, SUB=0 → SUM=0x80, C_out=0, OVF=1. Then X=0x80, Y=0xFF, C_in=1 → SUM=0x80, C_out=1, OVF=0.
- WIDTH=8, SLICE=2, SUB=1, X=0x05, Y=0x07, C_in=0 → SUM=0xFE, C_out=0 (borrow), OVF=0. Then X=0x80, Y=0x01, C_in=0 → SUM=0x7F, C_out=1, OVF=1.
- Back-pressure: OUT_READY=0 for 5 cycles after OUT_VALID. SUM, C_out and OVF stay constant, IN_READY=0, and an IN_VALID pulse is ignored. OUT_READY=1 → IDLE next cycle.
- Reset mid-operation: assert RST_N=0 at cnt=1. Outputs go to 0 and IN_READY to 1 without waiting for a clock edge. After release, a fresh 0x10+0x20 gives SUM=0x30 with the latency of a normal operation.
- WIDTH=16, SLICE=16 and WIDTH=16, SLICE=1: 1000 random operands each, checked against a reference model. Latency must be 1 and 16 cycles respectively.
